rx_pattern_checker: RTL

Receive-side checker that sits directly downstream of the 8b/10b decoder in the GTX loopback test path. It consumes decoded bytes plus the K flag and locks onto the transmitted test frame: 12 K characters followed by a 0x00..0xFF data ramp. Once locked, it counts symbol errors and completed frames, so link integrity can be read out without a logic analyser.

---
 rtl/gtx_pattern_pkg.sv | 51 +++++
 rtl/rx_pattern_checker_if.sv | 10 +
 rtl/rx_pattern_ref.sv | 23 ++
 rtl/rx_pattern_checker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gtx_pattern_pkg.sv
// Shared definition of the GTX loopback test frame: 12 K characters followed by
// a 0x00..0xFF data ramp. Used by both the transmit generator and the checker.
package gtx_pattern_pkg;

    localparam int FRAME_LEN = 268;
    localparam int K_LEN     = 12;

    localparam logic [8:0] POS_LAST  = 9'd267;
    localparam logic [8:0] K_LEN_POS = 9'd12;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // K character sent at header slot idx (0..11)
    function automatic logic [7:0] k_char(input logic [3:0] idx);
        logic [7:0] val;
        case (idx)
            4'd0:    val = K28_0;
            4'd1:    val = K28_1;
            4'd2:    val = K28_2;
            4'd3:    val = K28_3;
            4'd4:    val = K28_4;
            4'd5:    val = K28_5;
            4'd6:    val = K28_6;
            4'd7:    val = K28_7;
            4'd8:    val = K23_7;
            4'd9:    val = K27_7;
            4'd10:   val = K29_7;
            4'd11:   val = K30_7;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/rx_pattern_checker_if.sv
// Decoded-symbol stream from the 8b/10b decoder plus the counter clear strobe.
interface rx_pattern_checker_if;
    logic       valid;
    logic       k;
    logic [7:0] data;
    logic       clr;

    modport master (output valid, output k, output data, output clr);
    modport slave  (input  valid, input  k, input  data, input  clr);
endinterface

// File: rtl/rx_pattern_ref.sv
// Combinational frame reference: expected symbol (byte + K flag) at a frame position.
module rx_pattern_ref
    import gtx_pattern_pkg::*;
(
    input  logic [8:0] pos,
    output logic [7:0] exp_data,
    output logic       exp_k
);

    // Header slots come from the K table, the rest is the ramp pos-12
    always_comb begin
        exp_data = 8'h00;
        exp_k    = 1'b0;
        if (pos < K_LEN_POS) begin
            exp_k    = 1'b1;
            exp_data = k_char(pos[3:0]);
        end else begin
            exp_k    = 1'b0;
            exp_data = 8'(pos - K_LEN_POS);
        end
    end

endmodule

// File: rtl/rx_pattern_checker.sv
// Frame-locking checker for the GTX loopback pattern; counts symbol errors and
// completed frames once aligned.
module rx_pattern_checker
    import gtx_pattern_pkg::*;
#(
    parameter int LOCK_FRAMES = 2,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             VALID_IN,
    input  logic [7:0]       DATA_IN,
    input  logic             K_IN,
    input  logic             CLR_CNT,
    output logic             LOCKED,
    output logic             ERR_STROBE,
    output logic [CNT_W-1:0] ERR_COUNT,
    output logic [CNT_W-1:0] FRAME_COUNT
);

    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int CONS_W = $clog2(LOSS_THRESH + 1);
    localparam logic [GOOD_W-1:0] LOCK_FRAMES_C = GOOD_W'(LOCK_FRAMES);
    localparam logic [CONS_W-1:0] LOSS_THRESH_C = CONS_W'(LOSS_THRESH);

    state_e            state_q, state_d;
    logic [8:0]        pos_q, pos_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CONS_W-1:0] cons_q, cons_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              err_strobe_q, err_strobe_d;
    logic              locked_q, locked_d;

    logic [7:0]        exp_data_s;
    logic              exp_k_s;
    logic              match_s;
    logic              is_k28_0_s;
    logic [8:0]        pos_next_s;
    logic [GOOD_W-1:0] good_next_s;
    logic [CONS_W-1:0] cons_next_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    rx_pattern_ref u_ref (
        .pos      (pos_q),
        .exp_data (exp_data_s),
        .exp_k    (exp_k_s)
    );

    // Symbol compare against the reference and wrap-around position increment
    always_comb begin
        match_s     = VALID_IN && (K_IN == exp_k_s) && (DATA_IN == exp_data_s);
        is_k28_0_s  = K_IN && (DATA_IN == K28_0);
        good_next_s = good_q + GOOD_W'(1);
        cons_next_s = cons_q + CONS_W'(1);
        if (pos_q == POS_LAST) begin
            pos_next_s = 9'd0;
        end else begin
            pos_next_s = pos_q + 9'd1;
        end
    end

    // Next-state, position, lock/loss bookkeeping and saturating counters
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        good_d       = good_q;
        cons_d       = cons_q;
        err_cnt_d    = err_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        err_strobe_d = 1'b0;

        if (VALID_IN) begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_k28_0_s) begin
                        pos_d   = 9'd1;
                        good_d  = {GOOD_W{1'b0}};
                        state_d = ST_VERIFY;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_VERIFY: begin
                    if (match_s) begin
                        pos_d = pos_next_s;
                        if (pos_q == POS_LAST) begin
                            if (good_next_s == LOCK_FRAMES_C) begin
                                good_d  = {GOOD_W{1'b0}};
                                cons_d  = {CONS_W{1'b0}};
                                state_d = ST_LOCKED;
                            end else begin
                                good_d  = good_next_s;
                            end
                        end else begin
                            good_d = good_q;
                        end
                    end else if (is_k28_0_s) begin
                        // A stray frame start is taken as a fresh alignment attempt
                        pos_d   = 9'd1;
                        good_d  = {GOOD_W{1'b0}};
                        state_d = ST_VERIFY;
                    end else begin
                        pos_d   = 9'd0;
                        good_d  = {GOOD_W{1'b0}};
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    pos_d = pos_next_s;
                    if (match_s) begin
                        cons_d = {CONS_W{1'b0}};
                    end else begin
                        err_strobe_d = 1'b1;
                        err_cnt_d    = sat_inc(err_cnt_q);
                        if (cons_next_s == LOSS_THRESH_C) begin
                            cons_d  = {CONS_W{1'b0}};
                            pos_d   = 9'd0;
                            state_d = ST_SEARCH;
                        end else begin
                            cons_d  = cons_next_s;
                        end
                    end
                    if (pos_q == POS_LAST) begin
                        frame_cnt_d = sat_inc(frame_cnt_q);
                    end else begin
                        frame_cnt_d = frame_cnt_q;
                    end
                end
                default: begin
                    pos_d   = 9'd0;
                    state_d = ST_SEARCH;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (CLR_CNT) begin
            err_cnt_d   = {CNT_W{1'b0}};
            frame_cnt_d = {CNT_W{1'b0}};
        end else begin
            frame_cnt_d = frame_cnt_d;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_SEARCH;
            pos_q        <= 9'd0;
            good_q       <= {GOOD_W{1'b0}};
            cons_q       <= {CONS_W{1'b0}};
            err_cnt_q    <= {CNT_W{1'b0}};
            frame_cnt_q  <= {CNT_W{1'b0}};
            err_strobe_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            good_q       <= good_d;
            cons_q       <= cons_d;
            err_cnt_q    <= err_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            err_strobe_q <= err_strobe_d;
            locked_q     <= locked_d;
        end
    end

    assign LOCKED      = locked_q;
    assign ERR_STROBE  = err_strobe_q;
    assign ERR_COUNT   = err_cnt_q;
    assign FRAME_COUNT = frame_cnt_q;

endmodule
